btb_gshare_predictor: RTL
=========================

BTB_GSHARE_PREDICTOR -- requirements
Module: btb_gshare_predictor

Interface
REQ-001 SHALL have parameter SET_BITS, default 6: BTB set index width; the BTB has 2^SET_BITS sets.
REQ-002 SHALL have parameter WAYS, default 2: BTB associativity; legal values are 1, 2 and 4.
REQ-003 SHALL have parameter PHT_BITS, default 10: pattern history table index width; the PHT has 2^PHT_BITS 2-bit counters.
REQ-004 SHALL have parameter GHR_LEN, default 8: global history length, 1..PHT_BITS.
REQ-005 SHALL have parameter GSHARE, default 1: 1 = XOR history into the PHT index, 0 = bimodal indexing.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port rd_pc, input, 32 bits: fetch PC to predict.
REQ-009 SHALL have port pred_hit, output, 1 bit: rd_pc hits a valid BTB entry.
REQ-010 SHALL have port pred_taken, output, 1 bit: predict redirect.
REQ-011 SHALL have port pred_target, output, 32 bits: predicted target; 0 when pred_hit=0.
REQ-012 SHALL have port upd_valid, input, 1 bit: a resolved control-flow instruction is reported this cycle.
REQ-013 SHALL have port upd_pc, input, 32 bits: PC of the resolved instruction.
REQ-014 SHALL have port upd_cond, input, 1 bit: 1 = conditional branch, 0 = unconditional jump.
REQ-015 SHALL have port upd_taken, input, 1 bit: resolved direction; ignored when upd_cond=0 (treated as taken).
REQ-016 SHALL have port upd_target, input, 32 bits: resolved target.

Function
REQ-017 SHALL derive set = pc[SET_BITS+1:2] and tag = pc[31:SET_BITS+2]; pc[1:0] SHALL be ignored.
REQ-018 SHALL give each BTB entry the fields valid, tag, target and uncond, plus one replacement pointer per set of width log2(WAYS), absent when WAYS=1.
REQ-019 SHALL compute the PHT index as pc[PHT_BITS+1:2] XOR zero-extended GHR when GSHARE=1, and as pc[PHT_BITS+1:2] alone when GSHARE=0.
REQ-020 SHALL make lookup purely combinational from rd_pc and current state, with zero-cycle latency: pred_hit = any way with valid and matching tag.
REQ-021 SHALL set pred_taken = pred_hit AND (uncond OR PHT[idx][1]).
REQ-022 SHALL drive pred_target from the hit way; 1 hot way is guaranteed by REQ-027.
REQ-023 SHALL, on upd_valid with upd_cond=1, update PHT[idx(upd_pc, current GHR)] as a saturating counter (00..11, +1 if taken, -1 if not) and set GHR to {GHR[GHR_LEN-2:0], upd_taken}.
REQ-024 SHALL leave the PHT and GHR unchanged on upd_valid with upd_cond=0.
REQ-025 SHALL, for an effectively taken update (upd_cond=0 or upd_taken=1) that hits its set, rewrite target and uncond in the hit way, leave the pointer unchanged and allocate nothing.
REQ-026 SHALL, for an effectively taken update that misses, write the lowest-numbered invalid way if one exists, otherwise write the way at the set pointer and then increment the pointer modulo WAYS; the written entry gets valid=1, tag, target and uncond = !upd_cond.
REQ-027 SHALL NOT allocate on a not-taken conditional update; an existing entry is retained unchanged, so a tag is never duplicated within a set.
REQ-028 SHALL, when an update and a lookup touch the same set or PHT index in the same cycle, return pre-update state; the update is visible from the next cycle.
REQ-029 SHALL ignore all upd_* inputs when upd_valid=0, changing no state.

Reset
REQ-030 SHALL, when rst=1 at a clock edge, clear all valid bits, set all PHT counters to 01 (weakly not-taken), and set GHR and all pointers to 0.
REQ-031 SHALL give reset priority over a simultaneous update, discarding the update.
REQ-032 SHALL hold pred_hit=0, pred_taken=0 and pred_target=0 for any rd_pc in the cycle after reset.

Verification
REQ-033 SHALL cover a cold miss: after reset, rd_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0.
REQ-034 SHALL cover training: with GSHARE=0, two updates pc=0x100, cond=1, taken=1, target=0x200 -> next cycle rd_pc=0x100 gives pred_hit=1, pred_target=0x200 and pred_taken=1 (counter at 11 after 01->10->11).
REQ-035 SHALL cover an unconditional jump: update pc=0x300, cond=0, target=0x40 -> pred_taken=1 regardless of the PHT, and GHR unchanged.
REQ-036 SHALL cover set replacement: with WAYS=2, taken updates to three PCs mapping to set 0 (0x000, 0x100, 0x200 with SET_BITS=6) -> 0x000 evicted, 0x100 and 0x200 hit, pointer=1.
REQ-037 SHALL cover same-cycle bypass: update and lookup of the same new PC in one cycle -> pred_hit=0 that cycle and 1 the next.
REQ-038 SHALL cover reset mid-operation: rst asserted together with upd_valid -> all entries invalid, the update is not recorded, and GHR=0.

Source files
------------

// File: rtl/btb_gshare_predictor.sv
// Branch target buffer (set-associative, round-robin victim pointer per set) plus a
// gshare/bimodal pattern history table of 2-bit counters; lookup is zero-latency.
module btb_gshare_predictor #(
    parameter int unsigned SET_BITS = 6,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned PHT_BITS = 10,
    parameter int unsigned GHR_LEN  = 8,
    parameter int unsigned GSHARE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_cond,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned SETS     = 1 << SET_BITS;
    localparam int unsigned PHT_SIZE = 1 << PHT_BITS;
    localparam int unsigned TAG_W    = 30 - SET_BITS;
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic             uncond;
    } btb_entry_t;

    btb_entry_t           btb_q [SETS][WAYS];
    logic [1:0]           pht_q [PHT_SIZE];
    logic [GHR_LEN-1:0]   ghr_q;

    logic [SET_BITS-1:0]  rd_set;
    logic [TAG_W-1:0]     rd_tag;
    logic                 hit_uncond;

    logic [SET_BITS-1:0]  upd_set;
    logic [TAG_W-1:0]     upd_tag;
    logic [PHT_BITS-1:0]  upd_idx;
    logic                 upd_eff_taken;
    logic                 upd_hit;
    logic                 inv_found;
    logic [WAY_W-1:0]     hit_way;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     victim_way;
    logic [WAY_W-1:0]     ptr_cur;
    logic [1:0]           pht_cur;
    logic [1:0]           pht_next;
    logic [GHR_LEN-1:0]   ghr_next;

    logic                 unused_pc_lsbs;
    assign unused_pc_lsbs = ^{rd_pc[1:0], upd_pc[1:0]};

    function automatic logic [PHT_BITS-1:0] pht_index(input logic [31:0]        pc,
                                                      input logic [GHR_LEN-1:0] ghr);
        if (GSHARE != 0) return pc[PHT_BITS+1:2] ^ PHT_BITS'(ghr);
        return pc[PHT_BITS+1:2];
    endfunction

    // Lookup path: reads pre-update state only, so same-cycle updates are not bypassed
    always_comb begin
        rd_set      = rd_pc[SET_BITS+1:2];
        rd_tag      = rd_pc[31:SET_BITS+2];
        pred_hit    = 1'b0;
        pred_target = '0;
        hit_uncond  = 1'b0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (btb_q[rd_set][WAY_W'(w)].valid && btb_q[rd_set][WAY_W'(w)].tag == rd_tag) begin
                pred_hit    = 1'b1;
                pred_target = btb_q[rd_set][WAY_W'(w)].target;
                hit_uncond  = btb_q[rd_set][WAY_W'(w)].uncond;
            end
        end
        pred_taken = pred_hit && (hit_uncond || pht_q[pht_index(rd_pc, ghr_q)][1]);
    end

    always_comb begin
        upd_set       = upd_pc[SET_BITS+1:2];
        upd_tag       = upd_pc[31:SET_BITS+2];
        upd_idx       = pht_index(upd_pc, ghr_q);
        upd_eff_taken = !upd_cond || upd_taken;
        upd_hit       = 1'b0;
        inv_found     = 1'b0;
        hit_way       = '0;
        inv_way       = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (btb_q[upd_set][WAY_W'(w)].valid && btb_q[upd_set][WAY_W'(w)].tag == upd_tag) begin
                upd_hit = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!btb_q[upd_set][WAY_W'(w)].valid && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : ptr_cur;
        pht_cur    = pht_q[upd_idx];
        if (upd_taken) pht_next = (pht_cur == 2'b11) ? 2'b11 : pht_cur + 2'b01;
        else           pht_next = (pht_cur == 2'b00) ? 2'b00 : pht_cur - 2'b01;
        ghr_next   = GHR_LEN'({ghr_q, upd_taken});
    end

    // Per-set replacement pointer only advances when a full set is overwritten
    if (WAYS > 1) begin : g_ptr
        logic [WAY_W-1:0] ptr_q [SETS];
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < int'(SETS); s++) ptr_q[SET_BITS'(s)] <= '0;
            end else if (upd_valid && upd_eff_taken && !upd_hit && !inv_found) begin
                ptr_q[upd_set] <= ptr_q[upd_set] + WAY_W'(1);
            end
        end
        assign ptr_cur = ptr_q[upd_set];
    end else begin : g_no_ptr
        assign ptr_cur = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                for (int w = 0; w < int'(WAYS); w++) btb_q[SET_BITS'(s)][WAY_W'(w)].valid <= 1'b0;
            end
            for (int i = 0; i < int'(PHT_SIZE); i++) pht_q[PHT_BITS'(i)] <= 2'b01;
            ghr_q <= '0;
        end else if (upd_valid) begin
            if (upd_cond) begin
                pht_q[upd_idx] <= pht_next;
                ghr_q          <= ghr_next;
            end
            if (upd_eff_taken) begin
                if (upd_hit) begin
                    btb_q[upd_set][hit_way].target <= upd_target;
                    btb_q[upd_set][hit_way].uncond <= !upd_cond;
                end else begin
                    btb_q[upd_set][victim_way] <= '{valid: 1'b1, tag: upd_tag,
                                                   target: upd_target, uncond: !upd_cond};
                end
            end
        end
    end

endmodule
